upc_sequencer: RTL and testbench
================================

// Module: upc_sequencer
// PURPOSE
//  Command sequencer for unidadprocesadora: takes one macro-command per valid/ready handshake and emits
//  the 16-bit ctr_word stream {A[15:13],B[12:10],D[9:7],F[6:3],H[2:0]}, one word per clk.
//  Single-cycle ops (LOAD/ALU/CLR) take one word; MUL runs a shift-free repeated-add loop steered by
//  the registered flags stateBits={V,S,Z,C}. Sits between the host/test FSM and the processing unit.
// PARAMETERS
//  N        4  datapath width (must match processing unit)
//  SCRATCH  7  register index reserved as MUL loop counter (never a legal rd/ra/rb for MUL)
// PORTS
//  clk         in   1   clock, rising edge
//  rst_n       in   1   asynchronous, active-low reset
//  cmd_valid   in   1   command offered
//  cmd_ready   out  1   sequencer can accept (high only in IDLE)
//  cmd_op      in   3   000 NOP, 001 LOAD, 010 ALU, 011 CLR, 100 MUL, others illegal
//  cmd_rd      in   3   destination register
//  cmd_ra      in   3   A-source register (0 = DATA_in)
//  cmd_rb      in   3   B-source register (0 = DATA_in)
//  cmd_func    in   4   ALU F field (ALU op only)
//  cmd_shift   in   3   shifter H field (ALU op only)
//  state_bits  in   4   stateBits from the processing unit {V,S,Z,C}
//  ctr_word    out  16  control word to the processing unit
//  busy        out  1   command in progress (state != IDLE)
//  done        out  1   1-cycle pulse, coincident with the last control word of a command
//  cmd_err     out  1   1-cycle pulse, cycle after an illegal command is accepted
// BEHAVIOUR
//  Reset (async): state=IDLE, latched command=0; ctr_word=16'h0000, busy=0, done=0, cmd_err=0, cmd_ready=1.
//  ctr_word is combinational from state + latched command. IDLE/TEST drive 16'h0000, a no-write word.
//  Handshake: accept on posedge when cmd_valid&&cmd_ready; fields latched at that edge.
//   cmd_valid without ready is ignored.
//  Legality, checked at accept: rd==0 is illegal for LOAD/ALU/CLR/MUL.
//   For MUL, also illegal: rd==ra, rd==rb, or any of rd/ra/rb==SCRATCH.
//   Illegal op codes are illegal.
//   Illegal command: no words issued, state->ERR for 1 cycle (cmd_err=1, ctr_word=0), then IDLE.
//  NOP: EXEC 1 cycle, word 0, done=1.
//  Single-cycle ops: EXEC 1 cycle, done=1, then IDLE. Accept at edge t -> word in cycle t+1 -> ready in t+2.
//   LOAD: {0,0,rd,F_PASS,H_NONE}.  ALU: {ra,rb,rd,func,shift}.  CLR: {0,0,rd,F_PASS,H_ZERO}.
//  MUL  rd = (ra*rb) mod 2^N. States and words:
//   M_CLR  {0,0,rd,F_PASS,H_ZERO}               -> M_CNT
//   M_CNT  {rb,0,SCRATCH,F_PASS,H_NONE}         -> M_TEST
//   M_TEST 16'h0000; Z = state_bits[1] reflects the previous word (flags registered at that edge).
//          Z=1 -> done=1, go IDLE; Z=0 -> M_ADD.
//   M_ADD  {rd,ra,rd,F_ADD,H_NONE}              -> M_DEC
//   M_DEC  {SCRATCH,0,SCRATCH,F_DEC,H_NONE}     -> M_TEST
//   Total cycles = 3 + 3*k for multiplier value k (0..2^N-1). done is asserted in the final M_TEST.
//   rb==0 as register means DATA_in: the count is DATA_in sampled in M_CNT.
//  Boundary cases:
//   k=0 -> 3 cycles, rd=0.  k=15 -> 48 cycles, no early exit.
//   V/C flags are ignored (wrap is intentional).
//   cmd_valid high during busy is held off (ready=0), never dropped or merged.
//   Reset mid-command: immediate IDLE, ctr_word=0; partially written rd/SCRATCH values are undefined.
// STRUCTURE
//  Package upc_pkg holds:
//   - typedef enum {IDLE,EXEC,ERR,M_CLR,M_CNT,M_TEST,M_ADD,M_DEC} upc_state_t
//   - op codes OP_NOP..OP_MUL
//   - F_PASS=4'b0000, F_ADD=4'b0010, F_DEC=4'b0110, H_NONE=3'b000, H_ZERO=3'b011
//   - function make_cw(a,b,d,f,h) returning the 16-bit word.
//  No sub-module: one always_ff state/command register, one always_comb next-state/word decode.
// TESTING  (bench pairs upc_sequencer with unidadprocesadora, ctr_word->ctr_word, stateBits->state_bits)
//  LOAD rd=3, DATA_in=5 -> one word 16'h0180, done same cycle, R3=5 after edge.
//  ALU ra=1 rb=2 rd=4 func=0010 shift=000, R1=3 R2=6 -> word 16'h2A10, R4=9, DATA_out=9.
//  MUL rd=5 ra=1 rb=2, R1=3 R2=4 -> 15 cycles busy, done on cycle 15, R5=12.
//   Repeat with R2=0 -> 3 cycles, R5=0.
//  MUL rd=1 ra=1 rb=2 -> cmd_err pulse 1 cycle after accept, ctr_word stays 0, no register written.
//   LOAD rd=0 -> same response.
//  Assert rst_n=0 in M_ADD of MUL (R1=3, R2=5) -> same cycle: ctr_word=0, busy=0, cmd_ready=1.
//   Next LOAD then runs normally.
//  Back-to-back LOADs with cmd_valid held high -> accepted every 2 cycles, no lost or duplicated command.

Source files
------------

// File: rtl/upc_sequencer_pkg.sv
// ============================================================================
//  Module      : upc_pkg
//  Description : Shared types, op codes, field encodings and control-word
//                helpers for the unidadprocesadora command sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package upc_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        EXEC   = 3'd1,
        ERR    = 3'd2,
        M_CLR  = 3'd3,
        M_CNT  = 3'd4,
        M_TEST = 3'd5,
        M_ADD  = 3'd6,
        M_DEC  = 3'd7
    } upc_state_t;

    typedef logic [2:0] upc_op_t;

    localparam upc_op_t OP_NOP  = 3'b000;
    localparam upc_op_t OP_LOAD = 3'b001;
    localparam upc_op_t OP_ALU  = 3'b010;
    localparam upc_op_t OP_CLR  = 3'b011;
    localparam upc_op_t OP_MUL  = 3'b100;

    localparam logic [3:0] F_PASS = 4'b0000;
    localparam logic [3:0] F_ADD  = 4'b0010;
    localparam logic [3:0] F_DEC  = 4'b0110;
    localparam logic [2:0] H_NONE = 3'b000;
    localparam logic [2:0] H_ZERO = 3'b011;

    function automatic logic [15:0] make_cw(
        input logic [2:0] a,
        input logic [2:0] b,
        input logic [2:0] d,
        input logic [3:0] f,
        input logic [2:0] h
    );
        return {a, b, d, f, h};
    endfunction

    // MUL uses the scratch register as its loop counter, so no operand may alias it or rd.
    function automatic logic cmd_legal(
        input upc_op_t    op,
        input logic [2:0] rd,
        input logic [2:0] ra,
        input logic [2:0] rb,
        input logic [2:0] scratch
    );
        logic ok;
        case (op)
            OP_NOP:                  ok = 1'b1;
            OP_LOAD, OP_ALU, OP_CLR: ok = (rd != 3'd0);
            OP_MUL:                  ok = (rd != 3'd0) && (rd != ra) && (rd != rb) &&
                                          (rd != scratch) && (ra != scratch) && (rb != scratch);
            default:                 ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

`default_nettype wire

// File: rtl/upc_sequencer_if.sv
// ============================================================================
//  Module      : upc_sequencer_if
//  Description : Macro-command valid/ready bus between host FSM and sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface upc_sequencer_if;
    import upc_pkg::*;

    logic       cmd_valid;
    logic       cmd_ready;
    upc_op_t    cmd_op;
    logic [2:0] cmd_rd;
    logic [2:0] cmd_ra;
    logic [2:0] cmd_rb;
    logic [3:0] cmd_func;
    logic [2:0] cmd_shift;

    modport master (
        output cmd_valid, cmd_op, cmd_rd, cmd_ra, cmd_rb, cmd_func, cmd_shift,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_rd, cmd_ra, cmd_rb, cmd_func, cmd_shift,
        output cmd_ready
    );

endinterface

`default_nettype wire

// File: rtl/upc_sequencer.sv
// ============================================================================
//  Module      : upc_sequencer
//  Description : Turns macro-commands into the 16-bit ctr_word stream for the
//                processing unit; MUL is a flag-steered repeated-add loop.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module upc_sequencer
    import upc_pkg::*;
#(
    parameter int N       = 4,
    parameter int SCRATCH = 7
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    upc_sequencer_if.slave   cmd,
    input  wire logic [3:0]  state_bits,
    output logic      [15:0] ctr_word,
    output logic             busy,
    output logic             done,
    output logic             cmd_err
);

    localparam logic [2:0] c_SCRATCH = 3'(SCRATCH);

    generate
        if (N < 1 || N > 16 || SCRATCH < 1 || SCRATCH > 7) begin : g_bad_params
            $error("upc_sequencer: unsupported N/SCRATCH");
        end
    endgenerate

    upc_state_t r_state;
    upc_state_t w_next;
    upc_op_t    r_op;
    logic [2:0] r_rd;
    logic [2:0] r_ra;
    logic [2:0] r_rb;
    logic [3:0] r_func;
    logic [2:0] r_shift;

    logic       w_accept;
    logic       w_legal;
    logic       w_zero;
    logic       w_unused_flags;

    assign cmd.cmd_ready  = (r_state == IDLE);
    assign busy           = (r_state != IDLE);
    assign w_accept       = cmd.cmd_valid && cmd.cmd_ready;
    assign w_legal        = cmd_legal(cmd.cmd_op, cmd.cmd_rd, cmd.cmd_ra, cmd.cmd_rb, c_SCRATCH);
    // Only Z steers the loop; V/C wrap is intentional and S has no role here.
    assign w_zero         = state_bits[1];
    assign w_unused_flags = ^{state_bits[3:2], state_bits[0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_op    <= OP_NOP;
            r_rd    <= 3'd0;
            r_ra    <= 3'd0;
            r_rb    <= 3'd0;
            r_func  <= 4'd0;
            r_shift <= 3'd0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_op    <= cmd.cmd_op;
                r_rd    <= cmd.cmd_rd;
                r_ra    <= cmd.cmd_ra;
                r_rb    <= cmd.cmd_rb;
                r_func  <= cmd.cmd_func;
                r_shift <= cmd.cmd_shift;
            end
        end
    end

    always_comb begin
        w_next   = r_state;
        ctr_word = 16'h0000;
        done     = 1'b0;
        cmd_err  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (!w_legal)               w_next = ERR;
                    else if (cmd.cmd_op == OP_MUL) w_next = M_CLR;
                    else                        w_next = EXEC;
                end
            end
            EXEC: begin
                done   = 1'b1;
                w_next = IDLE;
                case (r_op)
                    OP_LOAD: ctr_word = make_cw(3'd0, 3'd0, r_rd, F_PASS, H_NONE);
                    OP_ALU:  ctr_word = make_cw(r_ra, r_rb, r_rd, r_func, r_shift);
                    OP_CLR:  ctr_word = make_cw(3'd0, 3'd0, r_rd, F_PASS, H_ZERO);
                    default: ctr_word = 16'h0000;
                endcase
            end
            ERR: begin
                cmd_err = 1'b1;
                w_next  = IDLE;
            end
            M_CLR: begin
                ctr_word = make_cw(3'd0, 3'd0, r_rd, F_PASS, H_ZERO);
                w_next   = M_CNT;
            end
            M_CNT: begin
                ctr_word = make_cw(r_rb, 3'd0, c_SCRATCH, F_PASS, H_NONE);
                w_next   = M_TEST;
            end
            // Z reflects the counter written by the previous word (M_CNT or M_DEC).
            M_TEST: begin
                if (w_zero) begin
                    done   = 1'b1;
                    w_next = IDLE;
                end else begin
                    w_next = M_ADD;
                end
            end
            M_ADD: begin
                ctr_word = make_cw(r_rd, r_ra, r_rd, F_ADD, H_NONE);
                w_next   = M_DEC;
            end
            M_DEC: begin
                ctr_word = make_cw(c_SCRATCH, 3'd0, c_SCRATCH, F_DEC, H_NONE);
                w_next   = M_TEST;
            end
            default: w_next = IDLE;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_upc_sequencer.sv
// ============================================================================
//  Module      : tb_upc_sequencer
//  Description : Scoreboarded bench for upc_sequencer driving a small
//                behavioural model of the processing unit.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_upc_sequencer;
    import upc_pkg::*;

    typedef struct {
        bit          err;
        logic [15:0] word;
        int          lat;
        bit          chk;
        int          ridx;
        logic [3:0]  rval;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  state_bits;
    logic [15:0] ctr_word;
    logic        busy, done, cmd_err;

    logic [3:0]  R [8] = '{default: 4'd0};
    logic        z = 1'b0;
    logic [3:0]  din = 4'd0;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc_cnt = 0;
    int          busy_cyc = 0;
    bit          pend = 0;
    int          pend_idx = 0;
    logic [3:0]  pend_val = 4'd0;

    upc_sequencer_if cif ();

    upc_sequencer #(.N(4), .SCRATCH(7)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd        (cif),
        .state_bits (state_bits),
        .ctr_word   (ctr_word),
        .busy       (busy),
        .done       (done),
        .cmd_err    (cmd_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    assign state_bits = {2'b00, z, 1'b0};

    function automatic logic [3:0] pu_res(input logic [15:0] w);
        logic [3:0] a, b, r;
        a = (w[15:13] == 3'd0) ? din : R[w[15:13]];
        b = (w[12:10] == 3'd0) ? din : R[w[12:10]];
        case (w[6:3])
            4'b0010: r = a + b;
            4'b0110: r = a - 4'd1;
            default: r = a;
        endcase
        if (w[2:0] == 3'b011) r = 4'd0;
        return r;
    endfunction

    // Processing-unit stand-in: destination 0 means no write, flags follow each write.
    always @(posedge clk) begin
        if (ctr_word[9:7] != 3'd0) begin
            R[ctr_word[9:7]] <= pu_res(ctr_word);
            z                <= (pu_res(ctr_word) == 4'd0);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            busy_cyc = 0;
        end else begin
            if (pend) begin
                check($sformatf("reg_R%0d", pend_idx), {28'd0, R[pend_idx]}, {28'd0, pend_val});
                pend = 0;
            end
            if (busy) busy_cyc++;
            else      busy_cyc = 0;
            if (done || cmd_err) begin
                if (q.size() == 0) begin
                    check("unexpected_completion", {30'd0, done, cmd_err}, 32'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("kind_done_err", {30'd0, done, cmd_err}, e.err ? 32'd1 : 32'd2);
                    check("last_word", {16'd0, ctr_word}, {16'd0, e.word});
                    check("latency", busy_cyc, e.lat);
                    if (e.chk) begin
                        pend     = 1;
                        pend_idx = e.ridx;
                        pend_val = e.rval;
                    end
                end
            end
        end
    end

    task automatic drive(input upc_op_t op, input logic [2:0] rd, ra, rb,
                         input logic [3:0] func, input logic [2:0] sh);
        cif.cmd_valid = 1'b1;
        cif.cmd_op    = op;
        cif.cmd_rd    = rd;
        cif.cmd_ra    = ra;
        cif.cmd_rb    = rb;
        cif.cmd_func  = func;
        cif.cmd_shift = sh;
    endtask

    task automatic push(input bit err, input logic [15:0] word, input int lat,
                        input bit chk, input int ridx, input logic [3:0] rval);
        exp_t e;
        e.err = err; e.word = word; e.lat = lat; e.chk = chk; e.ridx = ridx; e.rval = rval;
        q.push_back(e);
    endtask

    task automatic wait_accept(output bit ok);
        ok = 0;
        for (int n = 0; n < 100 && !ok; n++) begin
            if (cif.cmd_ready) begin
                @(posedge clk);
                ok = 1;
            end else begin
                @(negedge clk);
            end
        end
        #1;
    endtask

    task automatic send(input upc_op_t op, input logic [2:0] rd, ra, rb,
                        input logic [3:0] func, input logic [2:0] sh, input logic [3:0] d,
                        input bit err, input logic [15:0] word, input int lat,
                        input bit chk, input int ridx, input logic [3:0] rval);
        bit ok;
        @(negedge clk);
        drive(op, rd, ra, rb, func, sh);
        din = d;
        push(err, word, lat, chk, ridx, rval);
        wait_accept(ok);
        cif.cmd_valid = 1'b0;
        if (!ok) begin
            check("accept_timeout", 32'd0, 32'd1);
            void'(q.pop_back());
        end
        ok = 0;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clk);
            ok = cif.cmd_ready;
        end
        if (!ok) check("idle_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        bit ok;
        int acc [3];

        cif.cmd_valid = 1'b0;
        drive(OP_NOP, 3'd0, 3'd0, 3'd0, 4'd0, 3'd0);
        cif.cmd_valid = 1'b0;
        #3;
        check("rst_ctr_word", {16'd0, ctr_word}, 32'h0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_cmd_err", {31'd0, cmd_err}, 32'd0);
        check("rst_ready", {31'd0, cif.cmd_ready}, 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        //    op       rd    ra    rb    func     sh     din    err word      lat chk idx val
        send(OP_LOAD, 3'd3, 3'd0, 3'd0, 4'd0,    3'd0,  4'd5,  0, 16'h0180, 1,  1,  3, 4'd5);
        send(OP_LOAD, 3'd1, 3'd0, 3'd0, 4'd0,    3'd0,  4'd3,  0, 16'h0080, 1,  1,  1, 4'd3);
        send(OP_LOAD, 3'd2, 3'd0, 3'd0, 4'd0,    3'd0,  4'd6,  0, 16'h0100, 1,  1,  2, 4'd6);
        send(OP_ALU,  3'd4, 3'd1, 3'd2, 4'b0010, 3'd0,  4'd0,  0, 16'h2A10, 1,  1,  4, 4'd9);
        send(OP_CLR,  3'd4, 3'd0, 3'd0, 4'd0,    3'd0,  4'd0,  0, 16'h0203, 1,  1,  4, 4'd0);
        send(OP_NOP,  3'd0, 3'd0, 3'd0, 4'd0,    3'd0,  4'd0,  0, 16'h0000, 1,  0,  0, 4'd0);
        send(OP_LOAD, 3'd2, 3'd0, 3'd0, 4'd0,    3'd0,  4'd4,  0, 16'h0100, 1,  1,  2, 4'd4);
        send(OP_MUL,  3'd5, 3'd1, 3'd2, 4'd0,    3'd0,  4'd0,  0, 16'h0000, 15, 1,  5, 4'd12);
        send(OP_LOAD, 3'd2, 3'd0, 3'd0, 4'd0,    3'd0,  4'd0,  0, 16'h0100, 1,  1,  2, 4'd0);
        send(OP_MUL,  3'd5, 3'd1, 3'd2, 4'd0,    3'd0,  4'd0,  0, 16'h0000, 3,  1,  5, 4'd0);
        send(OP_MUL,  3'd6, 3'd1, 3'd0, 4'd0,    3'd0,  4'd15, 0, 16'h0000, 48, 1,  6, 4'd13);
        // Illegal commands: no word issued, target registers keep their values.
        send(OP_MUL,  3'd1, 3'd1, 3'd2, 4'd0,    3'd0,  4'd9,  1, 16'h0000, 1,  1,  1, 4'd3);
        send(OP_LOAD, 3'd0, 3'd0, 3'd0, 4'd0,    3'd0,  4'd9,  1, 16'h0000, 1,  1,  3, 4'd5);
        send(3'b101,  3'd2, 3'd0, 3'd0, 4'd0,    3'd0,  4'd9,  1, 16'h0000, 1,  1,  2, 4'd0);
        send(OP_MUL,  3'd7, 3'd1, 3'd2, 4'd0,    3'd0,  4'd9,  1, 16'h0000, 1,  1,  7, 4'd0);
        send(OP_LOAD, 3'd2, 3'd0, 3'd0, 4'd0,    3'd0,  4'd5,  0, 16'h0100, 1,  1,  2, 4'd5);

        // Reset while the MUL loop sits in M_ADD.
        @(negedge clk);
        drive(OP_MUL, 3'd5, 3'd1, 3'd2, 4'd0, 3'd0);
        wait_accept(ok);
        cif.cmd_valid = 1'b0;
        check("mid_accept", {31'd0, ok}, 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check("m_add_word", {16'd0, ctr_word}, 32'hA690);
        check("m_add_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_word", {16'd0, ctr_word}, 32'h0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_ready", {31'd0, cif.cmd_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        send(OP_LOAD, 3'd3, 3'd0, 3'd0, 4'd0, 3'd0, 4'd6, 0, 16'h0180, 1, 1, 3, 4'd6);

        // Back-to-back LOADs with cmd_valid held high.
        @(negedge clk);
        drive(OP_LOAD, 3'd1, 3'd0, 3'd0, 4'd0, 3'd0);
        din = 4'd10;
        push(0, 16'h0080, 1, 1, 1, 4'd10);
        for (int i = 0; i < 3; i++) begin
            wait_accept(ok);
            acc[i] = cyc_cnt;
            if (!ok) check("b2b_accept_timeout", 32'd0, 32'd1);
            if (i < 2) begin
                drive(OP_LOAD, 3'(i + 2), 3'd0, 3'd0, 4'd0, 3'd0);
                push(0, (i == 0) ? 16'h0100 : 16'h0180, 1, 1, i + 2, 4'(11 + i));
            end else begin
                cif.cmd_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            din = 4'(11 + i);
        end
        check("b2b_spacing_0", acc[1] - acc[0], 32'd2);
        check("b2b_spacing_1", acc[2] - acc[1], 32'd2);

        ok = 0;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            ok = (q.size() == 0) && !pend;
        end
        check("queue_drained", q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
